// File: rtl/muldiv_seq.sv
// Iterative HI/LO unit: shift-add multiply, optional restoring divide (`define MULDIV_DIV_EN), mthi/mtlo.
// Latency: mult/div result and done WIDTH+2 cycles after the start edge, div-by-zero after 1, mthi/mtlo at the start edge.
// Backpressure: none; start is honoured only in IDLE and dropped while busy or in FIX.
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [1:0]       sign,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic             busy,
  output logic             done
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
`ifdef MULDIV_DIV_EN
    DIV  = 2'd2,
`endif
    FIX  = 2'd3
  } state_t;

  state_t             state;
  logic [CW-1:0]      stepCnt;
  logic [2*WIDTH-1:0] acc;    // mult: {partial product, multiplier}; div: {remainder, dividend->quotient}
  logic [WIDTH-1:0]   opB;    // multiplicand or divisor magnitude
  logic               negLo;  // product / quotient must be negated

  logic               sgn;
  logic               unusedSign;
  logic [WIDTH-1:0]   magA;
  logic [WIDTH-1:0]   magB;
  logic               stepDone;
  logic [WIDTH:0]     mulSum;
  logic [2*WIDTH-1:0] mulNext;
  logic [2*WIDTH-1:0] mulFix;

  assign sgn        = sign[1];
  assign unusedSign = sign[0];
  assign magA       = (sgn && A[WIDTH-1]) ? -A : A;
  assign magB       = (sgn && B[WIDTH-1]) ? -B : B;
  // One extra cycle after the last step lets FIX load the sign-corrected result.
  assign stepDone   = (stepCnt == CW'(WIDTH));
  assign mulSum     = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opB} : '0);
  assign mulNext    = {mulSum, acc[WIDTH-1:1]};
  assign mulFix     = negLo ? -acc : acc;

`ifdef MULDIV_DIV_EN
  logic               negHi;  // remainder takes the dividend's sign
  logic [WIDTH:0]     divTrial;
  logic [2*WIDTH-1:0] divNext;
  logic [WIDTH-1:0]   quoFix;
  logic [WIDTH-1:0]   remFix;

  assign divTrial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opB};
  assign divNext  = divTrial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                    : {divTrial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
  assign quoFix   = negLo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
  assign remFix   = negHi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      stepCnt <= '0;
      acc     <= '0;
      opB     <= '0;
      negLo   <= 1'b0;
`ifdef MULDIV_DIV_EN
      negHi   <= 1'b0;
`endif
      HI      <= '0;
      LO      <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            stepCnt <= '0;
            case (op)
              OP_MULT: begin
                acc   <= {{WIDTH{1'b0}}, magB};
                opB   <= magA;
                negLo <= sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
                busy  <= 1'b1;
                state <= MUL;
              end
              OP_DIV: begin
`ifdef MULDIV_DIV_EN
                if (B == '0) begin
                  HI    <= A;
                  LO    <= '1;
                  done  <= 1'b1;
                  state <= FIX;
                end else begin
                  acc   <= {{WIDTH{1'b0}}, magA};
                  opB   <= magB;
                  negLo <= sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
                  negHi <= sgn && A[WIDTH-1];
                  busy  <= 1'b1;
                  state <= DIV;
                end
`endif
              end
              OP_MTHI: HI <= A;
              default: LO <= A;
            endcase
          end
        end
        MUL: begin
          if (stepDone) begin
            {HI, LO} <= mulFix;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= FIX;
          end else begin
            acc     <= mulNext;
            stepCnt <= stepCnt + CW'(1);
          end
        end
`ifdef MULDIV_DIV_EN
        DIV: begin
          if (stepDone) begin
            HI    <= remFix;
            LO    <= quoFix;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIX;
          end else begin
            acc     <= divNext;
            stepCnt <= stepCnt + CW'(1);
          end
        end
`endif
        FIX:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Bench for muldiv_seq: directed spot values plus random commands against a plain-arithmetic HI/LO model.
module tb_muldiv_seq;

  localparam int W   = 32;
  localparam int LAT = W + 2;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [1:0]   sign = 2'b00;
  logic [W-1:0] A = '0;
  logic [W-1:0] B = '0;
  logic [W-1:0] HI;
  logic [W-1:0] LO;
  logic         busy;
  logic         done;

  int errors = 0;
  int checks = 0;

  logic [W-1:0] mHi = '0;
  logic [W-1:0] mLo = '0;
  int expDone;
  int expBusy;

  muldiv_seq #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .sign(sign),
    .A(A), .B(B), .HI(HI), .LO(LO), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Architectural effect of one command: new HI/LO, done cycle (0 = never), busy cycle count.
  task automatic refOp(input logic [1:0] o, input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] pr;
    longint sa;
    longint sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    expDone = 0;
    expBusy = 0;
    case (o)
      2'b00: begin
        if (s[1]) pr = sa * sb;
        else      pr = {32'b0, a} * {32'b0, b};
        mHi = pr[2*W-1:W];
        mLo = pr[W-1:0];
        expDone = LAT;
        expBusy = LAT - 1;
      end
      2'b01: begin
`ifdef MULDIV_DIV_EN
        if (b == '0) begin
          mHi = a;
          mLo = '1;
          expDone = 1;
        end else begin
          if (s[1]) begin
            pr = sa / sb;
            mLo = pr[W-1:0];
            pr = sa % sb;
            mHi = pr[W-1:0];
          end else begin
            mLo = a / b;
            mHi = a % b;
          end
          expDone = LAT;
          expBusy = LAT - 1;
        end
`endif
      end
      2'b10:   mHi = a;
      default: mLo = a;
    endcase
  endtask

  // Drive one command, scramble A/B afterwards, and record done/busy activity over a fixed window.
  task automatic issue(input logic [1:0] o, input logic [1:0] s, input logic [W-1:0] a, input logic [W-1:0] b,
                       output int dFirst, output int dCnt, output int bFirst, output int bLast, output int bCnt);
    @(negedge clk);
    start = 1'b1; op = o; sign = s; A = a; B = b;
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom;
    dFirst = 0; dCnt = 0; bFirst = 0; bLast = 0; bCnt = 0;
    for (int c = 1; c <= LAT + 2; c++) begin
      if (done) begin
        if (dCnt == 0) dFirst = c;
        dCnt++;
      end
      if (busy) begin
        if (bCnt == 0) bFirst = c;
        bLast = c;
        bCnt++;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({HI, LO} !== '0) begin errors++; $display("FAIL reset_hilo: got %h_%h want 0_0", HI, LO); end
    checks++;
    if ({busy, done} !== 2'b00) begin errors++; $display("FAIL reset_flags: busy=%b done=%b want 0 0", busy, done); end
    // first edge after release must take the command
    reset = 1'b0; start = 1'b1; op = 2'b10; sign = 2'b00; A = 32'h5A5A1234;
    @(negedge clk);
    start = 1'b0;
    mHi = 32'h5A5A1234; mLo = '0;
    checks++;
    if (HI !== mHi || LO !== mLo) begin errors++; $display("FAIL first_start: got %h_%h want %h_%h", HI, LO, mHi, mLo); end
  endtask

  task automatic test_mult;
    logic [W-1:0] va[3] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'h80000000};
    logic [W-1:0] vb[3] = '{32'h00000002, 32'h00000007, 32'h80000000};
    logic [1:0]   vs[3] = '{2'b00, 2'b10, 2'b10};
    logic [W-1:0] eh[3] = '{32'h00000001, 32'hFFFFFFFF, 32'h40000000};
    logic [W-1:0] el[3] = '{32'hFFFFFFFE, 32'hFFFFFFEB, 32'h00000000};
    int dF, dC, bF, bL, bC;
    for (int i = 0; i < 3; i++) begin
      issue(2'b00, vs[i], va[i], vb[i], dF, dC, bF, bL, bC);
      mHi = eh[i]; mLo = el[i];
      checks++;
      if (HI !== eh[i] || LO !== el[i]) begin errors++; $display("FAIL mult_val[%0d]: got %h_%h want %h_%h", i, HI, LO, eh[i], el[i]); end
      checks++;
      if (dF != LAT || dC != 1) begin errors++; $display("FAIL mult_done[%0d]: cycle %0d count %0d want %0d 1", i, dF, dC, LAT); end
      checks++;
      if (bF != 1 || bL != LAT - 1 || bC != LAT - 1) begin errors++; $display("FAIL mult_busy[%0d]: cycles %0d..%0d n=%0d want 1..%0d", i, bF, bL, bC, LAT - 1); end
    end
  endtask

  task automatic test_div;
    int dF, dC, bF, bL, bC;
`ifdef MULDIV_DIV_EN
    logic [W-1:0] va[4] = '{32'hFFFFFFF9, 32'd100, 32'd5, 32'h80000000};
    logic [W-1:0] vb[4] = '{32'd2, 32'd7, 32'd0, 32'hFFFFFFFF};
    logic [1:0]   vs[4] = '{2'b10, 2'b00, 2'b10, 2'b10};
    logic [W-1:0] eh[4] = '{32'hFFFFFFFF, 32'd2, 32'd5, 32'd0};
    logic [W-1:0] el[4] = '{32'hFFFFFFFD, 32'd14, 32'hFFFFFFFF, 32'h80000000};
    int         edn[4] = '{LAT, LAT, 1, LAT};
    for (int i = 0; i < 4; i++) begin
      issue(2'b01, vs[i], va[i], vb[i], dF, dC, bF, bL, bC);
      mHi = eh[i]; mLo = el[i];
      checks++;
      if (HI !== eh[i] || LO !== el[i]) begin errors++; $display("FAIL div_val[%0d]: got %h_%h want %h_%h", i, HI, LO, eh[i], el[i]); end
      checks++;
      if (dF != edn[i] || dC != 1) begin errors++; $display("FAIL div_done[%0d]: cycle %0d count %0d want %0d 1", i, dF, dC, edn[i]); end
      checks++;
      if (bC != ((edn[i] == 1) ? 0 : LAT - 1)) begin errors++; $display("FAIL div_busy[%0d]: busy cycles %0d", i, bC); end
    end
`else
    issue(2'b01, 2'b10, 32'd5, 32'd3, dF, dC, bF, bL, bC);
    checks++;
    if (dC != 0 || bC != 0) begin errors++; $display("FAIL div_off_flags: done %0d busy %0d want 0 0", dC, bC); end
    checks++;
    if (HI !== mHi || LO !== mLo) begin errors++; $display("FAIL div_off_hilo: got %h_%h want %h_%h", HI, LO, mHi, mLo); end
`endif
  endtask

  task automatic test_mthi_mtlo;
    logic sawDone;
    logic [W-1:0] oldLo;
    oldLo = mLo;
    @(negedge clk);
    start = 1'b1; op = 2'b10; sign = 2'b00; A = 32'h12345678;
    @(negedge clk);
    sawDone = done;
    checks++;
    if (HI !== 32'h12345678 || LO !== oldLo) begin errors++; $display("FAIL mthi: got %h_%h want 12345678_%h", HI, LO, oldLo); end
    op = 2'b11; A = 32'hCAFEF00D;
    @(negedge clk);
    start = 1'b0;
    sawDone |= done;
    repeat (3) begin @(negedge clk); sawDone |= done | busy; end
    mHi = 32'h12345678; mLo = 32'hCAFEF00D;
    checks++;
    if (HI !== mHi || LO !== mLo) begin errors++; $display("FAIL mtlo: got %h_%h want %h_%h", HI, LO, mHi, mLo); end
    checks++;
    if (sawDone !== 1'b0) begin errors++; $display("FAIL mt_flags: done/busy seen %b want 0", sawDone); end
  endtask

  // Mult in flight; a div at cycle 5 and an mthi in the last busy and FIX cycles must all be dropped.
  task automatic test_busy_ignore;
    logic [W-1:0] a, b;
    int dF, dC, bC;
    logic late;
    a = 32'h00012345; b = 32'hFFFFFF00;
    refOp(2'b00, 2'b10, a, b);
    @(negedge clk);
    start = 1'b1; op = 2'b00; sign = 2'b10; A = a; B = b;
    @(negedge clk);
    dF = 0; dC = 0; bC = 0;
    for (int c = 1; c <= LAT + 2; c++) begin
      start = 1'b0;
      if (c == 5) begin start = 1'b1; op = 2'b01; A = ~a; B = b + 1; end
      if (c == LAT - 1 || c == LAT) begin start = 1'b1; op = 2'b10; A = 32'hDEADBEEF; end
      if (done) begin if (dC == 0) dF = c; dC++; end
      if (busy) bC++;
      @(negedge clk);
    end
    late = 1'b0;
    repeat (LAT + 4) begin @(negedge clk); late |= done | busy; end
    checks++;
    if (HI !== mHi || LO !== mLo) begin errors++; $display("FAIL busy_ignore_val: got %h_%h want %h_%h", HI, LO, mHi, mLo); end
    checks++;
    if (dF != LAT || dC != 1 || bC != LAT - 1) begin errors++; $display("FAIL busy_ignore_timing: done@%0d x%0d busy %0d", dF, dC, bC); end
    checks++;
    if (late !== 1'b0) begin errors++; $display("FAIL busy_ignore_late: stray activity %b want 0", late); end
  endtask

  task automatic test_random;
    logic [1:0]   o, s;
    logic [W-1:0] a, b;
    int dF, dC, bF, bL, bC, sel;
    for (int i = 0; i < 40; i++) begin
      o = 2'($urandom_range(0, 3)); s = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom;
      sel = $urandom_range(0, 9);
      if (sel == 0) b = '0;
      if (sel == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      if (sel == 2) b = 32'($urandom_range(1, 40));
      refOp(o, s, a, b);
      issue(o, s, a, b, dF, dC, bF, bL, bC);
      checks++;
      if (HI !== mHi || LO !== mLo) begin errors++; $display("FAIL rand_val[%0d] op=%0d s=%b a=%h b=%h: got %h_%h want %h_%h", i, o, s, a, b, HI, LO, mHi, mLo); end
      checks++;
      if (dF != expDone || dC != ((expDone == 0) ? 0 : 1)) begin errors++; $display("FAIL rand_done[%0d] op=%0d: done@%0d x%0d want @%0d", i, o, dF, dC, expDone); end
      checks++;
      if (bC != expBusy || (expBusy > 0 && (bF != 1 || bL != expBusy))) begin errors++; $display("FAIL rand_busy[%0d] op=%0d: %0d..%0d n=%0d want n=%0d", i, o, bF, bL, bC, expBusy); end
    end
  endtask

  task automatic test_reset_mid;
    int dF, dC, bF, bL, bC;
    logic seen;
    refOp(2'b10, 2'b00, 32'h0BADF00D, '0);
    issue(2'b10, 2'b00, 32'h0BADF00D, '0, dF, dC, bF, bL, bC);
    refOp(2'b11, 2'b00, 32'hFEEDFACE, '0);
    issue(2'b11, 2'b00, 32'hFEEDFACE, '0, dF, dC, bF, bL, bC);
    @(negedge clk);
    start = 1'b1; sign = 2'b10; A = 32'hFFFFFC18; B = 32'd3;
`ifdef MULDIV_DIV_EN
    op = 2'b01;
`else
    op = 2'b00;
`endif
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL rst_mid_busy: busy=%b at cycle 10 want 1", busy); end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({HI, LO} !== '0 || busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL rst_mid_async: %h_%h busy=%b done=%b want all 0", HI, LO, busy, done); end
    @(negedge clk);
    reset = 1'b0;
    mHi = '0; mLo = '0;
    seen = 1'b0;
    repeat (LAT + 6) begin @(negedge clk); seen |= done | busy; end
    checks++;
    if (seen !== 1'b0 || HI !== mHi || LO !== mLo) begin errors++; $display("FAIL rst_mid_after: activity=%b hilo=%h_%h want 0 0_0", seen, HI, LO); end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_busy_ignore();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
MULDIV_SEQ -- requirements
Module: muldiv_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, operand/HI/LO width; the iteration count equals WIDTH.
REQ-002 The block SHALL have port clk, input, 1, sole clock, rising-edge.
REQ-003 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1, command strobe, sampled only in IDLE.
REQ-005 The block SHALL have port op, input, 2, command: 00 mult, 01 div, 10 mthi, 11 mtlo.
REQ-006 The block SHALL have port sign, input, 2, signedness select; sign[1]=1 signed, sign[1]=0 unsigned, matching the ALU sign encoding; sign[0] is ignored.
REQ-007 The block SHALL have ports A and B, input, WIDTH each; A is the multiplicand/dividend/mthi-mtlo source and B is the multiplier/divisor.
REQ-008 The block SHALL have ports HI and LO, output, WIDTH each, registered architectural HI/LO.
REQ-009 The block SHALL have port busy, output, 1, high while an iterative operation is in flight.
REQ-010 The block SHALL have port done, output, 1, one-cycle pulse when HI/LO take a mult/div result.

Function
REQ-011 The FSM SHALL have exactly the states IDLE, MUL, DIV and FIX.
REQ-012 In IDLE with start=1, the block SHALL latch A, B, op and sign[1] at that edge (the start edge, cycle 0).
REQ-013 op=mult SHALL go to MUL and op=div SHALL go to DIV; busy=1 from cycle 1.
REQ-014 Signed operations SHALL iterate on magnitudes and record the result signs at the start edge.
REQ-015 MUL SHALL perform one shift-add step per cycle for WIDTH cycles, then go to FIX.
REQ-016 DIV SHALL perform one restoring step per cycle for WIDTH cycles, then go to FIX.
REQ-017 FIX SHALL apply sign correction, write HI/LO, drive done=1 and busy=0 for one cycle, then return to IDLE; HI/LO SHALL be valid WIDTH+2 cycles after the start edge (34 at WIDTH=32).
REQ-018 mult SHALL produce the full 2*WIDTH product, with HI = upper half and LO = lower half.
REQ-019 div SHALL produce LO = quotient truncated toward zero and HI = remainder carrying the sign of the dividend.
REQ-020 div with B=0 SHALL skip iteration and go directly to FIX, giving HI=A and LO=all ones, with done one cycle after the start edge.
REQ-021 Signed div of the most-negative value by -1 SHALL give LO=most-negative value and HI=0 with no exception.
REQ-022 mthi/mtlo SHALL write HI (resp. LO) from A at the start edge and leave the other register unchanged, with busy and done staying 0.
REQ-023 start while busy SHALL be ignored and SHALL NOT corrupt latched operands; the operand latch SHALL be used thereafter, so changes on A/B while busy have no effect.
REQ-024 HI/LO SHALL change only at a FIX cycle, an mthi/mtlo start edge, or reset.
REQ-025 start=1 in the FIX cycle SHALL be ignored; the next command is accepted in IDLE.

Reset
REQ-026 Assertion of reset SHALL asynchronously force state IDLE, HI=0, LO=0, busy=0, done=0 and clear the operand latches.
REQ-027 Reset asserted mid-operation SHALL abort the operation with no HI/LO write and no done pulse after release.
REQ-028 The first start SHALL be accepted at the first rising clk edge after reset deasserts.

Configuration
REQ-029 With macro MULDIV_DIV_EN defined, the divider datapath and the DIV state SHALL be compiled in.
REQ-030 Without MULDIV_DIV_EN, the divider datapath SHALL be absent and op=01 SHALL be a no-op: no busy, no done, HI/LO unchanged; mult, mthi and mtlo SHALL be unaffected.

Verification
REQ-031 Unsigned mult: A=0xFFFFFFFF, B=0x2 -> HI=0x00000001, LO=0xFFFFFFFE, done 34 cycles after the start edge, busy high cycles 1-33.
REQ-032 Signed mult: A=-3, B=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; and A=0x80000000, B=0x80000000 -> HI=0x40000000, LO=0.
REQ-033 Signed div: A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; unsigned A=100, B=7 -> LO=14, HI=2; A=5, B=0 -> HI=5, LO=0xFFFFFFFF with done at cycle 1.
REQ-034 mthi A=0x12345678 then mtlo A=0xCAFEF00D on consecutive cycles -> HI/LO hold those values, done never pulses.
REQ-035 Mult started, a second start (div) issued at cycle 5, and A/B changed -> only the mult result is written; the div is dropped.
REQ-036 Reset at cycle 10 of a div -> HI=LO=0, busy=0, and no done pulse after release; the build without MULDIV_DIV_EN shows no response to a div start.
